ram_dma: RTL and testbench
==========================

RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: word-address width, matching the single-port RAM it drives.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: transfer-length width in words.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  launch request, sampled only in IDLE.
- mode_i  in  1  0 = copy, 1 = fill; sampled with start_i.
- src_addr_i  in  ADDR_WIDTH  copy source word address.
- dst_addr_i  in  ADDR_WIDTH  destination word address.
- len_i  in  LEN_WIDTH  word count; 0 = no-op.
- fill_data_i  in  32  fill pattern.
- abort_i  in  1  cancel the active transfer.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- aborted_o  out  1  one-cycle abort pulse.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_be_o  out  4  RAM byte enables.
- ram_rdata_i  in  32  RAM read data, valid one cycle after a read access.

Function
REQ-004 SHALL act as the initiator of the single-port RAM interface, which has 1-cycle read latency, always-read behaviour and per-byte write enables.
REQ-005 SHALL implement states IDLE, RD, WR and DONE; busy_o SHALL be 1 in RD and WR only.
REQ-006 In IDLE with start_i=1, SHALL latch src, dst, len, mode and fill data.
- len=0: go to DONE, with no RAM access.
- copy: go to RD.
- fill: go to WR.
REQ-007 In RD, SHALL drive en=1, we=0, addr=src+i, then go to WR.
REQ-008 In WR, SHALL drive en=1, we=1, be=4'hF, addr=dst+i.
- wdata SHALL be ram_rdata_i in copy mode and the latched fill data in fill mode.
- i SHALL then increment.
- Next state: DONE after the last word; otherwise RD (copy) or WR (fill).
REQ-009 Copy SHALL take exactly 2*len cycles of RAM activity; fill SHALL take exactly len cycles.
REQ-010 DONE SHALL last one cycle, assert done_o=1 with busy_o=0, drive no RAM access, then return to IDLE.
REQ-011 Outside RD and WR, ram_en_o and ram_we_o SHALL be 0.
REQ-012 Addresses SHALL wrap modulo 2^ADDR_WIDTH; the word counter SHALL be LEN_WIDTH bits wide.
REQ-013 Copies SHALL run in ascending order only; overlapping copies with dst>src SHALL propagate earlier words, and this is the defined behaviour.
REQ-014 start_i outside IDLE SHALL be ignored.
REQ-015 abort_i in RD or WR SHALL return the block to IDLE on the next edge.
- aborted_o SHALL pulse for 1 cycle; done_o SHALL not pulse.
- A write issued in the abort cycle SHALL still complete.
REQ-016 abort_i and start_i asserted together in IDLE: start SHALL win, and abort SHALL be ignored.
REQ-017 All outputs SHALL be registered or decoded from registered state only.
- Exception: ram_wdata_o SHALL pass ram_rdata_i through in copy mode.

Reset
REQ-018 Asserting rst_n low SHALL asynchronously force IDLE and clear the counter and latched registers.
- Reset values: busy_o, done_o, aborted_o, ram_en_o and ram_we_o = 0; ram_addr_o = 0; ram_wdata_o = 0; ram_be_o = 4'hF.
REQ-019 Reset mid-transfer SHALL abandon the transfer without a done_o or aborted_o pulse; at most one partial write, issued in the preceding cycle, may have landed.

Structure
REQ-020 SHALL place the state enum and mode constants (MODE_COPY, MODE_FILL) in package ram_dma_pkg.
REQ-021 SHALL be a single module with no sub-module; the bench SHALL instantiate the RAM model separately.

Verification
REQ-022 Copy, src=0x10, dst=0x40, len=4, RAM[0x10..0x13]=A,B,C,D -> RAM[0x40..0x43]=A,B,C,D; busy_o high for 8 cycles; done_o pulses once.
REQ-023 Fill, dst=0x20, len=3, fill=0xDEADBEEF -> three writes on consecutive cycles with be=4'hF; done_o pulses on the cycle after the last write.
REQ-024 len=0 -> ram_en_o never high; done_o pulses on the cycle after start_i.
REQ-025 Copy, dst=0xFE, len=4, ADDR_WIDTH=8 -> writes land at 0xFE, 0xFF, 0x00, 0x01.
REQ-026 abort_i after 2 words of a len=8 copy -> aborted_o pulses; only the words written before abort are changed; no done_o.
REQ-027 rst_n low during WR of a fill -> all outputs take their reset values immediately; a following start_i runs normally.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the single-port RAM DMA engine.
package ram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma.sv
// DMA initiator for a 1-cycle-latency single-port RAM: ascending word copy
// (read/write alternating) or constant fill, with abort and completion pulses.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [31:0]           fill_data_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [31:0]           fill_q, fill_d;
    logic                  aborted_q, aborted_d;

    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [ADDR_WIDTH-1:0] offset;

    assign cnt_inc = cnt_q + 1'b1;
    // Size cast zero-extends or truncates the word index so addresses wrap.
    assign offset  = ADDR_WIDTH'(cnt_q);

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d  = src_addr_i;
                    dst_d  = dst_addr_i;
                    len_d  = len_i;
                    mode_d = mode_i;
                    fill_d = fill_data_i;
                    cnt_d  = '0;
                    if (len_i == '0)
                        state_d = ST_DONE;
                    else if (mode_i == MODE_FILL)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                cnt_d = cnt_inc;
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_inc == len_q) begin
                    state_d = ST_DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= MODE_COPY;
            fill_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs decode from registered state; only copy write data is a
    // combinational pass-through of the RAM read port.
    assign busy_o      = (state_q == ST_RD) || (state_q == ST_WR);
    assign done_o      = (state_q == ST_DONE);
    assign aborted_o   = aborted_q;
    assign ram_en_o    = busy_o;
    assign ram_we_o    = (state_q == ST_WR);
    assign ram_be_o    = 4'hF;
    assign ram_addr_o  = (state_q == ST_RD) ? src_q + offset :
                         (state_q == ST_WR) ? dst_q + offset : '0;
    assign ram_wdata_o = (state_q != ST_WR)      ? 32'h0 :
                         (mode_q == MODE_COPY)   ? ram_rdata_i : fill_q;

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: vector table of complete transfers plus
// hand sequences for start-while-busy, abort, start+abort and async reset.
`timescale 1ns/1ps
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [7:0]  src_addr_i = '0;
    logic [7:0]  dst_addr_i = '0;
    logic [7:0]  len_i = '0;
    logic [31:0] fill_data_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, aborted_o, ram_en_o, ram_we_o;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i;

    always #5 clk = ~clk;

    ram_dma #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .fill_data_i(fill_data_i), .abort_i(abort_i), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o), .ram_en_o(ram_en_o),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction

    // Single-port RAM model: always-read, 1-cycle read latency, byte writes.
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i[7:0]);
        end else if (ram_en_o) begin
            ram_rdata_i <= mem[ram_addr_o];
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end
        end
    end

    int total = 0, bad = 0;
    int busy_n, en_n, wr_n, done_n, ab_n, be_bad, en_idle;
    logic [7:0]  first_a, last_a;
    logic [31:0] last_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic clr();
        busy_n = 0; en_n = 0; wr_n = 0; done_n = 0; ab_n = 0; be_bad = 0; en_idle = 0;
        first_a = '0; last_a = '0; last_d = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        busy_n += int'(busy_o);
        en_n   += int'(ram_en_o);
        done_n += int'(done_o);
        ab_n   += int'(aborted_o);
        if (ram_en_o && !busy_o) en_idle++;
        if (ram_en_o && ram_we_o) begin
            wr_n++;
            if (wr_n == 1) first_a = ram_addr_o;
            last_a = ram_addr_o;
            last_d = ram_wdata_o;
            if (ram_be_o != 4'hF) be_bad++;
        end
    endtask

    task automatic reinit_mem();
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [31:0] f);
        clr();
        mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = l; fill_data_i = f;
        start_i = 1'b1;
    endtask

    task automatic finish_xfer(input string name);
        int lim;
        lim = 0;
        while (done_n == 0 && ab_n == 0 && lim < 600) begin
            tick();
            lim++;
        end
        chk({name, "_timeout"}, (lim < 600) ? 32'd1 : 32'd0, 32'd1);
        tick();
        tick();
    endtask

    typedef struct {
        logic        mode;
        logic [7:0]  src, dst, len;
        logic [31:0] fill;
        int          e_busy, e_wr;
        logic [7:0]  e_first, e_last;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 8'h10, 8'h40, 8'd4, 32'h0,        8, 4, 8'h40, 8'h43, 32'hC0DE0013};
        vecs[1] = '{1'b1, 8'h00, 8'h20, 8'd3, 32'hDEADBEEF, 3, 3, 8'h20, 8'h22, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'h10, 8'h40, 8'd0, 32'h0,        0, 0, 8'h00, 8'h00, 32'h0};
        vecs[3] = '{1'b0, 8'h05, 8'hFE, 8'd4, 32'h0,        8, 4, 8'hFE, 8'h01, 32'hC0DE0008};
        vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'd2, 32'h12345678, 2, 2, 8'hFF, 8'h00, 32'h12345678};
        vecs[5] = '{1'b0, 8'h30, 8'h31, 8'd3, 32'h0,        6, 3, 8'h31, 8'h33, 32'hC0DE0030};

        clr();
        tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_aborted", aborted_o, 1'b0);
        chk("rst_en", ram_en_o, 1'b0);
        chk("rst_we", ram_we_o, 1'b0);
        chk("rst_addr", ram_addr_o, 8'h00);
        chk("rst_wdata", ram_wdata_o, 32'h0);
        chk("rst_be", ram_be_o, 4'hF);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            reinit_mem();
            launch(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
            tick();
            start_i = 1'b0;
            if (vecs[v].len == 0) begin
                chk($sformatf("v%0d_done_next", v), done_o, 1'b1);
                chk($sformatf("v%0d_busy_len0", v), busy_o, 1'b0);
            end
            finish_xfer($sformatf("v%0d", v));
            chk($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].e_busy);
            chk($sformatf("v%0d_en_cycles", v), en_n, vecs[v].e_busy);
            chk($sformatf("v%0d_writes", v), wr_n, vecs[v].e_wr);
            chk($sformatf("v%0d_done_pulses", v), done_n, 1);
            chk($sformatf("v%0d_abort_pulses", v), ab_n, 0);
            chk($sformatf("v%0d_be_bad", v), be_bad, 0);
            chk($sformatf("v%0d_en_idle", v), en_idle, 0);
            if (vecs[v].e_wr != 0) begin
                chk($sformatf("v%0d_first_addr", v), first_a, vecs[v].e_first);
                chk($sformatf("v%0d_last_addr", v), last_a, vecs[v].e_last);
                chk($sformatf("v%0d_last_data", v), last_d, vecs[v].e_data);
            end
            if (v == 0) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("v0_mem_%0d", i), mem[8'h40 + i], 32'hC0DE0010 + i);
                chk("v0_mem_untouched", mem[8'h44], 32'hC0DE0044);
            end
            if (v == 3) chk("v3_mem_wrap", mem[8'h00], 32'hC0DE0007);
            if (v == 5) chk("v5_mem_overlap", mem[8'h32], 32'hC0DE0030);
        end

        // start_i while busy must not relaunch or alter the transfer
        reinit_mem();
        launch(1'b0, 8'h10, 8'h40, 8'd4, 32'h0);
        tick();
        start_i = 1'b0;
        tick();
        mode_i = 1'b1; dst_addr_i = 8'h80; len_i = 8'd9; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        finish_xfer("ign");
        chk("ign_busy_cycles", busy_n, 8);
        chk("ign_writes", wr_n, 4);
        chk("ign_last_addr", last_a, 8'h43);
        chk("ign_mem80", mem[8'h80], 32'hC0DE0080);

        // abort during the third word's read of a len=8 copy
        reinit_mem();
        launch(1'b0, 8'h10, 8'h50, 8'd8, 32'h0);
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abt_pulse", aborted_o, 1'b1);
        chk("abt_busy", busy_o, 1'b0);
        repeat (3) tick();
        chk("abt_pulses", ab_n, 1);
        chk("abt_done", done_n, 0);
        chk("abt_writes", wr_n, 2);
        chk("abt_mem50", mem[8'h50], 32'hC0DE0010);
        chk("abt_mem51", mem[8'h51], 32'hC0DE0011);
        chk("abt_mem52", mem[8'h52], 32'hC0DE0052);

        // start and abort together in IDLE: start wins
        launch(1'b1, 8'h00, 8'h90, 8'd2, 32'h55AA55AA);
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        finish_xfer("sa");
        chk("sa_writes", wr_n, 2);
        chk("sa_aborted", ab_n, 0);
        chk("sa_done", done_n, 1);
        chk("sa_mem91", mem[8'h91], 32'h55AA55AA);

        // asynchronous reset during a fill write, then a normal transfer
        launch(1'b1, 8'h00, 8'h60, 8'd5, 32'h11112222);
        tick();
        start_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy_o, 1'b0);
        chk("ar_done", done_o, 1'b0);
        chk("ar_aborted", aborted_o, 1'b0);
        chk("ar_en", ram_en_o, 1'b0);
        chk("ar_we", ram_we_o, 1'b0);
        chk("ar_addr", ram_addr_o, 8'h00);
        chk("ar_wdata", ram_wdata_o, 32'h0);
        chk("ar_be", ram_be_o, 4'hF);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_done_after", done_n, 0);
        chk("ar_abort_after", ab_n, 0);
        launch(1'b1, 8'h00, 8'h70, 8'd2, 32'hCAFEF00D);
        tick();
        start_i = 1'b0;
        finish_xfer("ar_rerun");
        chk("ar_rerun_writes", wr_n, 2);
        chk("ar_rerun_last", last_a, 8'h71);
        chk("ar_rerun_done", done_n, 1);
        chk("ar_rerun_mem71", mem[8'h71], 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
